logic_unit_checker: RTL and testbench

Self-checking response scoreboard for the bitwise logic units in the teacher-core IP library (OR gate, AND, XOR, NOR). It sits at the consuming end of a unit-test harness: it accepts the same operand/opcode stream that is driven into the unit under test, queues the expected results, and compares them in order against the results the unit returns. It reports pass/fail counts, captures the first mismatch, and issues a single end-of-test verdict. It is synthesizable, so it runs both in simulation and on the board.

---
 rtl/logic_unit_checker.sv | 185 ++++++++++++++++++
 tb/tb_logic_unit_checker.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_checker.sv
// logic_unit_checker: in-order response scoreboard for the bitwise logic units.
// Expected results are queued from the stimulus stream and compared against returned results.
module logic_unit_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int CNTW    = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stim_valid,
    output logic             stim_ready,
    input  logic [1:0]       stim_op,
    input  logic [WIDTH-1:0] stim_a,
    input  logic [WIDTH-1:0] stim_b,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_y,
    input  logic             eot,
    output logic [CNTW-1:0]  pass_cnt,
    output logic [CNTW-1:0]  fail_cnt,
    output logic [CNTW-1:0]  first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic [WIDTH-1:0] first_fail_got,
    output logic             overflow,
    output logic             underflow,
    output logic             timeout,
    output logic             done,
    output logic             pass,
    output logic [1:0]       dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Handshakes: a stimulus beat transfers on a rising edge where stim_valid && stim_ready;
    // stim_ready depends only on registered state. res_valid has no back-pressure.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_exp_mem [DEPTH];
    logic [CNTW-1:0]  r_idx_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNTW-1:0]  r_seq;
    logic [TW-1:0]    r_drain_cnt;
    logic [CNTW-1:0]  r_pass_cnt;
    logic [CNTW-1:0]  r_fail_cnt;
    logic [CNTW-1:0]  r_ff_idx;
    logic [WIDTH-1:0] r_ff_exp;
    logic [WIDTH-1:0] r_ff_got;
    logic             r_ovf;
    logic             r_udf;
    logic             r_to;
    logic             r_pass;

    logic             w_empty;
    logic             w_full;
    logic             w_active;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic             w_to_set;
    logic             w_match;
    logic             w_mismatch;
    logic             w_enter_done;
    logic             w_verdict;
    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-1:0] w_head_exp;
    logic [CNTW-1:0]  w_head_idx;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_active   = (r_state != ST_DONE);
    assign w_push     = (r_state == ST_RUN) && stim_valid && !w_full;
    assign w_ovf_set  = (r_state == ST_RUN) && stim_valid && w_full;
    assign w_pop      = w_active && res_valid && !w_empty;
    assign w_udf_set  = w_active && res_valid && w_empty;
    assign w_head_exp = r_exp_mem[r_rd_ptr[AW-1:0]];
    assign w_head_idx = r_idx_mem[r_rd_ptr[AW-1:0]];
    assign w_match    = w_pop && (w_head_exp == res_y);
    assign w_mismatch = w_pop && (w_head_exp != res_y);

    always_comb begin
        w_exp = '0;
        case (stim_op)
            2'b00:   w_exp = stim_a & stim_b;
            2'b01:   w_exp = stim_a | stim_b;
            2'b10:   w_exp = stim_a ^ stim_b;
            default: w_exp = ~(stim_a | stim_b);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_set    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (eot) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end else if (r_drain_cnt == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_to_set    = 1'b1;
                end
            end
            default: w_state_nxt = ST_DONE;
        endcase
    end

    // The verdict must include any fail or flag that lands on the same edge as DONE entry.
    assign w_enter_done = (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);
    assign w_verdict    = (r_fail_cnt == '0) && !w_mismatch && !r_ovf && !r_udf && !w_udf_set && !w_to_set;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_exp_mem[r_wr_ptr[AW-1:0]] <= w_exp;
            r_idx_mem[r_wr_ptr[AW-1:0]] <= r_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_seq       <= '0;
            r_drain_cnt <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= '0;
            r_ff_got    <= '0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_to        <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                r_seq    <= r_seq + CNTW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_udf_set) r_udf <= 1'b1;
            if (w_to_set)  r_to  <= 1'b1;
            if (w_match && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNTW'(1);
            if (w_mismatch) begin
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNTW'(1);
                if (r_fail_cnt == '0) begin
                    r_ff_idx <= w_head_idx;
                    r_ff_exp <= w_head_exp;
                    r_ff_got <= res_y;
                end
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + TW'(1) : '0;
            if (w_enter_done) r_pass <= w_verdict;
        end
    end

    assign stim_ready     = (r_state == ST_RUN) && !w_full;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_exp = r_ff_exp;
    assign first_fail_got = r_ff_got;
    assign overflow       = r_ovf;
    assign underflow      = r_udf;
    assign timeout        = r_to;
    assign done           = (r_state == ST_DONE);
    assign pass           = r_pass;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_logic_unit_checker.sv
// Bench for logic_unit_checker: directed scenarios plus a randomized run, all checked
// against a queue-based reference model that follows the scoreboard's rules.
module tb_logic_unit_checker;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int CNTW    = 16;
    localparam int TIMEOUT = 256;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stim_valid;
    logic             stim_ready;
    logic [1:0]       stim_op;
    logic [WIDTH-1:0] stim_a;
    logic [WIDTH-1:0] stim_b;
    logic             res_valid;
    logic [WIDTH-1:0] res_y;
    logic             eot;
    logic [CNTW-1:0]  pass_cnt;
    logic [CNTW-1:0]  fail_cnt;
    logic [CNTW-1:0]  first_fail_idx;
    logic [WIDTH-1:0] first_fail_exp;
    logic [WIDTH-1:0] first_fail_got;
    logic             overflow;
    logic             underflow;
    logic             timeout;
    logic             done;
    logic             pass;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    logic_unit_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stim_valid(stim_valid), .stim_ready(stim_ready),
        .stim_op(stim_op), .stim_a(stim_a), .stim_b(stim_b),
        .res_valid(res_valid), .res_y(res_y), .eot(eot),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got),
        .overflow(overflow), .underflow(underflow), .timeout(timeout),
        .done(done), .pass(pass), .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected queue plus plain integer counters and a phase number.
    typedef struct {
        logic [WIDTH-1:0] val;
        logic [CNTW-1:0]  idx;
    } entry_t;

    entry_t           m_q[$];
    int               m_seq, m_pass, m_fail, m_phase, m_drain_cycles;
    logic [CNTW-1:0]  m_ffi;
    logic [WIDTH-1:0] m_ffe, m_ffg;
    bit               m_ovf, m_udf, m_to, m_verdict;

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic model_step();
        bit     was_empty, was_full;
        entry_t h, e;
        if (rst) begin
            m_q.delete();
            m_seq = 0; m_pass = 0; m_fail = 0; m_phase = 0; m_drain_cycles = 0;
            m_ffi = '0; m_ffe = '0; m_ffg = '0;
            m_ovf = 0; m_udf = 0; m_to = 0; m_verdict = 0;
            return;
        end
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        if (m_phase != 2 && res_valid) begin
            if (was_empty) begin
                m_udf = 1;
            end else begin
                h = m_q.pop_front();
                if (h.val === res_y) begin
                    m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
                end else begin
                    if (m_fail == 0) begin m_ffi = h.idx; m_ffe = h.val; m_ffg = res_y; end
                    m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
                end
            end
        end
        if (m_phase == 0 && stim_valid) begin
            if (was_full) begin
                m_ovf = 1;
            end else begin
                e.val = ref_op(stim_op, stim_a, stim_b);
                e.idx = CNTW'(m_seq);
                m_q.push_back(e);
                m_seq = (m_seq + 1) % (1 << CNTW);
            end
        end
        if (m_phase == 0) begin
            if (eot) begin m_phase = 1; m_drain_cycles = 0; end
        end else if (m_phase == 1) begin
            m_drain_cycles++;
            if (!was_empty && m_drain_cycles == TIMEOUT) m_to = 1;
            if (was_empty || m_drain_cycles == TIMEOUT) begin
                m_phase   = 2;
                m_verdict = (m_fail == 0) && !m_ovf && !m_udf && !m_to;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        stim_valid = 0; stim_op = 0; stim_a = 0; stim_b = 0;
        res_valid = 0; res_y = 0; eot = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic end_test();
        set_idle();
        eot = 1;
        tick();
        eot = 0;
    endtask

    // Bounded wait; the caller checks done afterwards, so an expired bound shows up as a failure.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < TIMEOUT + 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({pass_cnt, fail_cnt, first_fail_idx} !== '0) begin
            n_fail++; $display("FAIL reset_counters got %h required 0", {pass_cnt, fail_cnt, first_fail_idx});
        end
        n_tests++;
        if ({first_fail_exp, first_fail_got} !== '0) begin
            n_fail++; $display("FAIL reset_first_fail got %h required 0", {first_fail_exp, first_fail_got});
        end
        n_tests++;
        if ({overflow, underflow, timeout, done, pass} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b required 00000", {overflow, underflow, timeout, done, pass});
        end
        n_tests++;
        if (stim_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_stim_ready got %b required 1", stim_ready);
        end
    endtask

    task automatic test_or_sequence();
        logic [WIDTH-1:0] a_tab [5];
        logic [WIDTH-1:0] b_tab [5];
        logic [WIDTH-1:0] ret[$];
        int               cyc;
        a_tab = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF};
        b_tab = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h007FA509, 32'hFFFFFFFF};
        do_reset();
        for (int i = 0; i <= 5; i++) begin
            set_idle();
            if (i > 0) begin res_valid = 1; res_y = ret.pop_front(); end
            if (i < 5) begin
                stim_valid = 1; stim_op = 2'b01; stim_a = a_tab[i]; stim_b = b_tab[i];
                ret.push_back(a_tab[i] | b_tab[i]);
                n_tests++;
                if (stim_ready !== 1'b1) begin
                    n_fail++; $display("FAIL or_stim_ready beat %0d got %b required 1", i, stim_ready);
                end
            end
            tick();
        end
        end_test();
        wait_done(cyc);
        n_tests++;
        if (cyc != 1) begin
            n_fail++; $display("FAIL or_drain_cycles got %0d required 1", cyc);
        end
        n_tests++;
        if (pass_cnt !== 16'd5 || fail_cnt !== 16'd0) begin
            n_fail++; $display("FAIL or_counts got pass=%0d fail=%0d required pass=5 fail=0", pass_cnt, fail_cnt);
        end
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            n_fail++; $display("FAIL or_verdict got done=%b pass=%b required done=1 pass=1", done, pass);
        end
    endtask

    task automatic test_mismatch();
        logic [WIDTH-1:0] ret[$];
        int               cyc;
        do_reset();
        for (int i = 0; i <= 4; i++) begin
            set_idle();
            if (i > 0) begin res_valid = 1; res_y = ret.pop_front(); end
            if (i < 4) begin
                stim_valid = 1; stim_op = 2'b00;
                stim_a = (i == 2) ? 32'hF0F0F0F0 : $urandom();
                stim_b = (i == 2) ? 32'hFF00FF00 : $urandom();
                ret.push_back((i == 2) ? 32'h0 : (stim_a & stim_b));
            end
            tick();
        end
        n_tests++;
        if (fail_cnt !== 16'd1 || pass_cnt !== 16'd3) begin
            n_fail++; $display("FAIL mm_counts got pass=%0d fail=%0d required pass=3 fail=1", pass_cnt, fail_cnt);
        end
        n_tests++;
        if (first_fail_idx !== 16'd2 || first_fail_exp !== 32'hF000F000 || first_fail_got !== 32'h0) begin
            n_fail++;
            $display("FAIL mm_capture got idx=%0d exp=%h got=%h required idx=2 exp=f000f000 got=00000000",
                     first_fail_idx, first_fail_exp, first_fail_got);
        end
        end_test();
        wait_done(cyc);
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            n_fail++; $display("FAIL mm_verdict got done=%b pass=%b required done=1 pass=0", done, pass);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] ret[$];
        int               cyc;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_idle();
            stim_valid = 1; stim_op = 2'($urandom_range(0, 3)); stim_a = $urandom(); stim_b = $urandom();
            if (i < 8) ret.push_back(ref_op(stim_op, stim_a, stim_b));
            n_tests++;
            if (stim_ready !== (i < 8)) begin
                n_fail++; $display("FAIL ovf_stim_ready beat %0d got %b required %b", i, stim_ready, (i < 8));
            end
            tick();
        end
        set_idle();
        n_tests++;
        if (overflow !== 1'b1 || stim_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_flag got ovf=%b ready=%b required ovf=1 ready=0", overflow, stim_ready);
        end
        for (int i = 0; i < 8; i++) begin
            res_valid = 1; res_y = ret.pop_front();
            tick();
        end
        end_test();
        wait_done(cyc);
        n_tests++;
        if (pass_cnt !== 16'd8 || fail_cnt !== 16'd0 || done !== 1'b1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_final got pass_cnt=%0d fail_cnt=%0d done=%b pass=%b required 8 0 1 0",
                     pass_cnt, fail_cnt, done, pass);
        end
    endtask

    task automatic test_underflow();
        int cyc;
        do_reset();
        res_valid = 1; res_y = $urandom();
        tick();
        set_idle();
        n_tests++;
        if (underflow !== 1'b1 || pass_cnt !== '0 || fail_cnt !== '0) begin
            n_fail++; $display("FAIL udf_flag got udf=%b pass_cnt=%0d fail_cnt=%0d required 1 0 0", underflow, pass_cnt, fail_cnt);
        end
        end_test();
        wait_done(cyc);
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            n_fail++; $display("FAIL udf_verdict got done=%b pass=%b required done=1 pass=0", done, pass);
        end
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] first;
        int               cyc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            stim_valid = 1; stim_op = 2'b10; stim_a = $urandom(); stim_b = $urandom();
            if (i == 0) first = stim_a ^ stim_b;
            tick();
        end
        set_idle();
        res_valid = 1; res_y = first;
        tick();
        end_test();
        wait_done(cyc);
        n_tests++;
        if (cyc != TIMEOUT) begin
            n_fail++; $display("FAIL to_latency got %0d required %0d", cyc, TIMEOUT);
        end
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || pass_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL to_final got done=%b timeout=%b pass=%b pass_cnt=%0d required 1 1 0 1",
                     done, timeout, pass, pass_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ret[$];
        int               bad_ready;
        bad_ready = 0;
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            set_idle();
            if (i > 0) begin res_valid = 1; res_y = ret.pop_front(); end
            if (i < 20) begin
                stim_valid = 1; stim_op = 2'b11; stim_a = $urandom(); stim_b = $urandom();
                ret.push_back(~(stim_a | stim_b));
                if (stim_ready !== 1'b1) bad_ready++;
            end
            tick();
        end
        n_tests++;
        if (bad_ready != 0) begin
            n_fail++; $display("FAIL b2b_ready got %0d refused beats required 0", bad_ready);
        end
        n_tests++;
        if (pass_cnt !== 16'd20 || fail_cnt !== 16'd0) begin
            n_fail++; $display("FAIL b2b_counts got pass=%0d fail=%0d required pass=20 fail=0", pass_cnt, fail_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            set_idle();
            stim_valid = 1; stim_op = 2'b11; stim_a = $urandom(); stim_b = $urandom();
            tick();
        end
        end_test();
        tick();
        n_tests++;
        if (done !== 1'b0 || stim_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_draining got done=%b ready=%b required done=0 ready=0", done, stim_ready);
        end
        rst = 1;
        tick();
        rst = 0;
        n_tests++;
        if ({pass_cnt, fail_cnt, first_fail_idx, first_fail_exp, first_fail_got,
             overflow, underflow, timeout, done, pass} !== '0 || stim_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset got pass_cnt=%0d fail_cnt=%0d flags=%b ready=%b required all 0 ready=1",
                     pass_cnt, fail_cnt, {overflow, underflow, timeout, done, pass}, stim_ready);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] flip;
        int               cyc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_idle();
            stim_valid = ($urandom_range(0, 3) != 0);
            stim_op    = 2'($urandom_range(0, 3));
            stim_a     = $urandom();
            stim_b     = $urandom();
            res_valid  = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            flip       = ($urandom_range(0, 19) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            res_y      = res_valid ? (m_q[0].val ^ flip) : $urandom();
            n_tests++;
            if (stim_ready !== (m_phase == 0 && m_q.size() < DEPTH)) begin
                n_fail++; $display("FAIL rnd_ready cycle %0d got %b required %b", i, stim_ready, (m_q.size() < DEPTH));
            end
            tick();
            n_tests++;
            if (pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
                n_fail++;
                $display("FAIL rnd_counts cycle %0d got pass=%0d fail=%0d required pass=%0d fail=%0d",
                         i, pass_cnt, fail_cnt, m_pass, m_fail);
            end
        end
        end_test();
        wait_done(cyc);
        n_tests++;
        if (first_fail_idx !== m_ffi || first_fail_exp !== m_ffe || first_fail_got !== m_ffg) begin
            n_fail++;
            $display("FAIL rnd_capture got idx=%0d exp=%h got=%h required idx=%0d exp=%h got=%h",
                     first_fail_idx, first_fail_exp, first_fail_got, m_ffi, m_ffe, m_ffg);
        end
        n_tests++;
        if ({overflow, underflow, timeout} !== {m_ovf, m_udf, m_to} || done !== (m_phase == 2) || pass !== m_verdict) begin
            n_fail++;
            $display("FAIL rnd_final got ovf/udf/to=%b done=%b pass=%b required %b %b %b",
                     {overflow, underflow, timeout}, done, pass, {m_ovf, m_udf, m_to}, (m_phase == 2), m_verdict);
        end
    endtask

    initial begin
        rst = 1;
        set_idle();
        test_reset();
        test_or_sequence();
        test_mismatch();
        test_overflow();
        test_underflow();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d tests", n_tests);
        $fatal(1);
    end

endmodule
